// File: rtl/dac_stream_fifo_if.sv
// Handshake bundle around the DAC stream FIFO: upstream IQ samples in, AXI-Stream samples out.
// The slave modport is the FIFO's own view; master is the view of whatever surrounds it.
interface dac_stream_fifo_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] iq_sample;
  logic              valid_iq;
  logic              last_iq;
  logic              ready_iq;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport slave (
    input  iq_sample, valid_iq, last_iq, m_axis_tready,
    output ready_iq, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output iq_sample, valid_iq, last_iq, m_axis_tready,
    input  ready_iq, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/dac_stream_fifo.sv
// Circular sample buffer feeding a DAC, with pulse tracking and a saturating underflow counter.
// Storage holds {tlast, tdata}; only the control state is reset.
module dac_stream_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  dac_stream_fifo_if.slave           bus,
  input  logic                       flush,
  input  logic                       clr_underflow,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       afull,
  output logic                       active,
  output logic [15:0]                underflow_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [DATA_W:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [LVL_W-1:0] level_q, level_d;
  state_t           state_q, state_d;
  logic [15:0]      underCnt_q, underCnt_d;

  logic            fifoFull;
  logic            fifoEmpty;
  logic            pushEn;
  logic            popEn;
  logic            underHit;
  logic [DATA_W:0] headEntry;

  // Ready depends only on registered occupancy, never on the DAC's tready.
  assign fifoFull  = (level_q == LVL_W'(DEPTH));
  assign fifoEmpty = (level_q == '0);
  assign headEntry = mem_q[rdPtr_q];

  assign bus.ready_iq      = !rst && !fifoFull && !flush;
  assign bus.m_axis_tvalid = !rst && !fifoEmpty;
  assign bus.m_axis_tdata  = headEntry[DATA_W-1:0];
  assign bus.m_axis_tlast  = headEntry[DATA_W];

  assign pushEn   = bus.valid_iq && bus.ready_iq;
  assign popEn    = bus.m_axis_tvalid && bus.m_axis_tready && !flush;
  assign underHit = (state_q == STREAM) && fifoEmpty && bus.m_axis_tready && !flush;

  assign level         = level_q;
  assign afull         = !rst && (level_q >= LVL_W'(AFULL_LVL));
  assign active        = !rst && (state_q == STREAM);
  assign underflow_cnt = underCnt_q;

  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    level_d    = level_q;
    state_d    = state_q;
    underCnt_d = underCnt_q;

    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      level_d = '0;
      state_d = IDLE;
    end else begin
      if (pushEn) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (popEn) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
        // The popped sample's tlast alone decides whether a pulse is now open or closed.
        state_d = bus.m_axis_tlast ? IDLE : STREAM;
      end
      case ({pushEn, popEn})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    if (clr_underflow) underCnt_d = '0;
    else if (underHit && (underCnt_q != 16'hFFFF)) underCnt_d = underCnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      level_q    <= '0;
      state_q    <= IDLE;
      underCnt_q <= '0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      underCnt_q <= underCnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn) mem_q[wrPtr_q] <= {bus.last_iq, bus.iq_sample};
  end

endmodule

// File: doc/dac_stream_fifo.md
DAC_STREAM_FIFO -- requirements
Module: dac_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample (tdata) width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2, occupancy at or above which afull asserts.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- iq_sample  in  DATA_W  upstream tdata.
- valid_iq  in  1  upstream tvalid.
- last_iq  in  1  upstream tlast, marks the final sample of a pulse.
- ready_iq  out  1  upstream tready.
- m_axis_tdata  out  DATA_W  DAC tdata.
- m_axis_tvalid  out  1  DAC tvalid.
- m_axis_tready  in  1  DAC tready.
- m_axis_tlast  out  1  DAC tlast.
- flush  in  1  synchronous buffer discard.
- clr_underflow  in  1  clears the underflow counter.
- level  out  $clog2(DEPTH+1)  current occupancy.
- afull  out  1  level >= AFULL_LVL.
- active  out  1  pulse in progress.
- underflow_cnt  out  16  saturating underflow count.

Function
REQ-005 SHALL store {tlast, tdata} in a DEPTH-entry circular buffer with rd/wr pointers wrapping modulo DEPTH.
REQ-006 SHALL drive ready_iq = (level != DEPTH) && !flush, with no combinational path from m_axis_tready.
REQ-007 SHALL push on valid_iq && ready_iq, and pop on m_axis_tvalid && m_axis_tready.
REQ-008 SHALL drive m_axis_tvalid = (level != 0), with m_axis_tdata/m_axis_tlast taken from the entry at rd pointer.
REQ-009 SHALL make a pushed sample visible on m_axis the cycle after the push; minimum latency 1 cycle.
REQ-010 SHALL sustain one push and one pop per cycle: simultaneous push+pop leaves level unchanged, and both pointers advance.
REQ-011 SHALL block pushes when full (ready_iq=0), even if a pop occurs that cycle; there is no pass-through at full.
REQ-012 SHALL update level as +1 on push only, -1 on pop only, and 0 otherwise; level never exceeds DEPTH or goes below 0.
REQ-013 SHALL hold m_axis_tdata/m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-014 SHALL implement an active state machine with two states:
- IDLE -> STREAM on a pop with m_axis_tlast=0.
- STREAM -> IDLE on a pop with m_axis_tlast=1.
- A single-sample pulse (a pop with tlast=1 in IDLE) stays in IDLE.
- active=1 in STREAM.
REQ-015 SHALL count underflow when state=STREAM, level=0 and m_axis_tready=1: +1 per such cycle, saturating at 16'hFFFF.
REQ-016 SHALL on flush=1:
- clear pointers and level to 0 and return the state machine to IDLE next cycle.
- ignore push/pop in that cycle.
- leave underflow_cnt unchanged.
REQ-017 SHALL on clr_underflow=1 set underflow_cnt to 0 next cycle, with the clear taking priority over a simultaneous increment.
REQ-018 SHALL NOT reset the storage array contents; only control state is reset.

Reset
REQ-019 SHALL, while rst=1 at a clk edge, set pointers=0, level=0, state=IDLE and underflow_cnt=0.
REQ-020 SHALL hold the following values during and immediately after reset: ready_iq=0 during reset, and 1 the first cycle after deassertion.
REQ-021 SHALL hold m_axis_tvalid=0, afull=0 and active=0 during and immediately after reset.
REQ-022 SHALL give rst priority over flush, clr_underflow and all handshakes.
REQ-023 SHALL, on reset asserted mid-pulse, drop all buffered samples and leave active=0 and m_axis_tvalid=0 next cycle.

Verification
REQ-024 Fill case: DEPTH=8, tready=0, push 8 samples 0x1..0x8 -> ready_iq=0 after the 8th, level=8, afull=1 from level 6, and a 9th valid is not accepted.
REQ-025 Streaming case: tready=1, continuous valid with samples 0x10..0x1F -> output equals input in order with 1-cycle latency, and level stays at or below 1.
REQ-026 Full with simultaneous pop: level=8 and tready=1 with valid_iq=1 -> that cycle pops only, level goes to 7, then the push is accepted next cycle.
REQ-027 Underflow case: push 2 samples with tlast=0, tready held 1, no further pushes for 5 cycles -> active=1 and underflow_cnt=4 (counting starts after the 2nd pop); pushing a tlast=1 sample then drains it and returns active to 0.
REQ-028 Flush mid-pulse: level=5 in STREAM with flush=1 for one cycle -> next cycle level=0, m_axis_tvalid=0, active=0, and underflow_cnt unchanged.
REQ-029 Saturation case: force 65540 underflow cycles -> underflow_cnt=16'hFFFF; clr_underflow together with an underflow cycle -> 0.
